// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare/bimodal branch direction predictor with GHR and init sweep
// Saturating-counter table indexed by PC (optionally xor GHR); speculative GHR with mispredict repair.
module gshare_predictor #(
  parameter int IDX_W  = 5,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 5,
  parameter int MODE   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              ready,
  input  logic              pred_valid,
  input  logic [IDX_W-1:0]  pred_pc_idx,
  output logic              pred_taken,
  output logic [HIST_W-1:0] pred_ghr,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_pc_idx,
  input  logic [HIST_W-1:0] upd_ghr,
  input  logic              upd_taken,
  input  logic              upd_mispredict
);

  localparam int DEPTH = 2**IDX_W;
  localparam logic [CTR_W-1:0] INIT_CTR = CTR_W'(2**(CTR_W-1) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  init_ptr;
  logic [HIST_W-1:0] ghr;
  logic [CTR_W-1:0]  table_q [DEPTH];

  logic [IDX_W-1:0]  pred_idx;
  logic [IDX_W-1:0]  upd_idx;
  logic [CTR_W-1:0]  upd_ctr;
  logic [CTR_W-1:0]  upd_ctr_next;
  logic [HIST_W:0]   spec_shift;
  logic [HIST_W:0]   repair_shift;

  always_comb begin
    if (MODE == 1) begin
      pred_idx = pred_pc_idx ^ IDX_W'(ghr);
      upd_idx  = upd_pc_idx ^ IDX_W'(upd_ghr);
    end else begin
      pred_idx = pred_pc_idx;
      upd_idx  = upd_pc_idx;
    end
  end

  always_comb begin
    upd_ctr      = table_q[upd_idx];
    upd_ctr_next = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != CTR_MAX) upd_ctr_next = upd_ctr + CTR_W'(1);
    end else begin
      if (upd_ctr != '0) upd_ctr_next = upd_ctr - CTR_W'(1);
    end
  end

  // Shift through a HIST_W+1 vector so HIST_W=1 needs no special case.
  assign spec_shift   = {ghr, pred_taken};
  assign repair_shift = {upd_ghr, upd_taken};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  state_next = (!clear && init_ptr == '1) ? S_RUN : S_INIT;
      S_RUN:   state_next = clear ? S_INIT : S_RUN;
      default: state_next = S_INIT;
    endcase
  end

  always_comb begin
    ready = (state == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_ptr <= '0;
      ghr      <= '0;
    end else if (clear) begin
      init_ptr <= '0;
      ghr      <= '0;
    end else if (state == S_INIT) begin
      init_ptr <= init_ptr + IDX_W'(1);
    end else if (upd_valid && upd_mispredict) begin
      ghr <= repair_shift[HIST_W-1:0];
    end else if (pred_valid) begin
      ghr <= spec_shift[HIST_W-1:0];
    end
  end

  // Table has no reset; the INIT sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      table_q[init_ptr] <= INIT_CTR;
    end else if (upd_valid && !clear) begin
      table_q[upd_idx] <= upd_ctr_next;
    end
  end

  assign pred_taken = ready & table_q[pred_idx][CTR_W-1];
  assign pred_ghr   = ghr;

endmodule
